// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// Single-beat req/ack: the master holds every request field stable until ack.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: issues single-beat data-memory requests for loads and
// stores, stalls the core until completion, and flags misalignment/timeouts.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic [31:0] mem_data,
  output logic        stall,
  output logic        mem_err,
  load_store_unit_if.master dmem
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LB  = 7'd26;
  localparam logic [6:0] OP_LH  = 7'd27;
  localparam logic [6:0] OP_LW  = 7'd28;
  localparam logic [6:0] OP_LBU = 7'd29;
  localparam logic [6:0] OP_LHU = 7'd30;
  localparam logic [6:0] OP_SB  = 7'd31;
  localparam logic [6:0] OP_SH  = 7'd32;
  localparam logic [6:0] OP_SW  = 7'd33;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              mem_err_q, mem_err_d;

  logic       is_load, is_store, is_mem, misaligned, load_q;
  logic [3:0] st_be;
  logic [31:0] st_wdata;

  // Picks the addressed byte/half out of the read word and extends it.
  function automatic logic [31:0] extract(input logic [6:0] op,
                                          input logic [1:0] lane,
                                          input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[7:0];
    unique case (lane)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    r = rdata;
    if (op == OP_LB)       r = {{24{b[7]}}, b};
    else if (op == OP_LBU) r = {24'd0, b};
    else if (op == OP_LH)  r = {{16{h[15]}}, h};
    else if (op == OP_LHU) r = {16'd0, h};
    return r;
  endfunction

  // Operation decode and store lane steering.
  always_comb begin
    is_load  = (operation >= OP_LB) && (operation <= OP_LHU);
    is_store = (operation >= OP_SB) && (operation <= OP_SW);
    is_mem   = is_load || is_store;
    load_q   = (op_q >= OP_LB) && (op_q <= OP_LHU);
    misaligned = 1'b0;
    if ((operation == OP_LH) || (operation == OP_LHU) || (operation == OP_SH))
      misaligned = alu_result[0];
    else if ((operation == OP_LW) || (operation == OP_SW))
      misaligned = (alu_result[1:0] != 2'b00);
    st_be    = 4'b1111;
    st_wdata = store_data;
    if (operation == OP_SB) begin
      st_be    = 4'b0001 << alu_result[1:0];
      st_wdata = {4{store_data[7:0]}};
    end else if (operation == OP_SH) begin
      st_be    = 4'b0011 << {alu_result[1], 1'b0};
      st_wdata = {2{store_data[15:0]}};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lane_d     = lane_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            state_d    = S_DONE;
            mem_err_d  = 1'b1;
            mem_data_d = 32'd0;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            op_d    = operation;
            lane_d  = alu_result[1:0];
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = is_store ? st_be : 4'b1111;
            wdata_d = is_store ? st_wdata : wdata_q;
          end
        end
      end
      S_REQ: begin
        if (dmem.dmem_ack) begin
          if (load_q) mem_data_d = extract(op_q, lane_q, dmem.dmem_rdata);
          mem_err_d = 1'b0;
          req_d     = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_err_d  = 1'b1;
          mem_data_d = 32'd0;
          req_d      = 1'b0;
          state_d    = S_DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 7'd0;
      lane_q     <= 2'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      mem_data_q <= 32'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign stall           = is_mem && (state_q != S_DONE);
  assign mem_data        = mem_data_q;
  assign mem_err         = mem_err_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so the abort path
// is reachable; each task drives one scenario and checks its own results.
module tb_load_store_unit;
  localparam logic [6:0] NOP = 7'd5;
  localparam logic [6:0] LB = 7'd26, LH = 7'd27, LW = 7'd28, LBU = 7'd29,
                         LHU = 7'd30, SB = 7'd31, SH = 7'd32, SW = 7'd33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  operation;
  logic [31:0] alu_result, store_data, mem_data;
  logic        stall, mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .alu_result(alu_result),
    .store_data(store_data), .mem_data(mem_data), .stall(stall),
    .mem_err(mem_err), .dmem(bus)
  );

  always #5 clk = ~clk;

  int          st_n, rq_n;
  logic        we_s;
  logic [31:0] addr_s, wd_s;
  logic [3:0]  be_s;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one op and plays memory, acking after ack_delay wait cycles.
  // Returns in the DONE cycle (first cycle with stall low).
  task automatic run_op(input logic [6:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int ack_delay);
    bit done = 1'b0;
    st_n = 0; rq_n = 0; we_s = 1'b0; addr_s = '0; be_s = '0; wd_s = '0;
    operation = op; alu_result = addr; store_data = sd;
    bus.dmem_rdata = rd; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
      end else begin
        st_n++;
        if (bus.dmem_req) begin
          rq_n++;
          we_s = bus.dmem_we; addr_s = bus.dmem_addr;
          be_s = bus.dmem_be; wd_s = bus.dmem_wdata;
        end
        bus.dmem_ack = bus.dmem_req && ((rq_n - 1) >= ack_delay);
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL op_complete: op %0d never left stall within 40 cycles", op);
    end
  endtask

  task automatic finish_op();
    operation = NOP;
    bus.dmem_ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; operation = NOP; alu_result = '0; store_data = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    cyc(); cyc();
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.dmem_req); end
    n_cmp++; if ({bus.dmem_we, bus.dmem_be} !== 5'd0) begin n_bad++; $display("FAIL rst_we_be: got %b want 0", {bus.dmem_we, bus.dmem_be}); end
    n_cmp++; if ({bus.dmem_addr, bus.dmem_wdata} !== 64'd0) begin n_bad++; $display("FAIL rst_addr_wdata: got %h want 0", {bus.dmem_addr, bus.dmem_wdata}); end
    n_cmp++; if ({mem_data, mem_err} !== 33'd0) begin n_bad++; $display("FAIL rst_mem: got %h want 0", {mem_data, mem_err}); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_loads();
    run_op(LB, 32'h103, 32'h0, 32'h80AA_BBCC, 0);
    n_cmp++; if (be_s !== 4'b1111 || we_s !== 1'b0) begin n_bad++; $display("FAIL lb_be_we: got %b/%b want 1111/0", be_s, we_s); end
    n_cmp++; if (addr_s !== 32'h100) begin n_bad++; $display("FAIL lb_addr: got %h want 00000100", addr_s); end
    n_cmp++; if (mem_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", mem_data); end
    n_cmp++; if (st_n !== 2 || rq_n !== 1) begin n_bad++; $display("FAIL lb_stall: got stall %0d req %0d want 2/1", st_n, rq_n); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL lb_err: got %b want 0", mem_err); end
    finish_op();
    run_op(LBU, 32'h103, 32'h0, 32'h80AA_BBCC, 0);
    n_cmp++; if (mem_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", mem_data); end
    finish_op();
    run_op(LB, 32'h101, 32'h0, 32'h80AA_BBCC, 0);
    n_cmp++; if (mem_data !== 32'hFFFF_FFBB) begin n_bad++; $display("FAIL lb_lane1: got %h want ffffffbb", mem_data); end
    finish_op();
    run_op(LH, 32'h102, 32'h0, 32'h8001_1234, 2);
    n_cmp++; if (mem_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data: got %h want ffff8001", mem_data); end
    n_cmp++; if (st_n !== 4 || rq_n !== 3) begin n_bad++; $display("FAIL lh_wait_stall: got stall %0d req %0d want 4/3", st_n, rq_n); end
    finish_op();
    run_op(LHU, 32'h102, 32'h0, 32'h8001_1234, 0);
    n_cmp++; if (mem_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_data: got %h want 00008001", mem_data); end
    finish_op();
    run_op(LH, 32'h100, 32'h0, 32'h8001_1234, 0);
    n_cmp++; if (mem_data !== 32'h0000_1234) begin n_bad++; $display("FAIL lh_low: got %h want 00001234", mem_data); end
    finish_op();
    run_op(LW, 32'h100, 32'h0, 32'h8001_1234, 0);
    n_cmp++; if (mem_data !== 32'h8001_1234) begin n_bad++; $display("FAIL lw_data: got %h want 80011234", mem_data); end
    finish_op();
  endtask

  task automatic test_stores();
    run_op(SB, 32'h2, 32'h1234_56AB, 32'hFFFF_FFFF, 0);
    n_cmp++; if (we_s !== 1'b1 || be_s !== 4'b0100) begin n_bad++; $display("FAIL sb_we_be: got %b/%b want 1/0100", we_s, be_s); end
    n_cmp++; if (wd_s !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata: got %h want abababab", wd_s); end
    n_cmp++; if (mem_data !== 32'h8001_1234) begin n_bad++; $display("FAIL sb_keep_data: got %h want 80011234", mem_data); end
    finish_op();
    run_op(SH, 32'h2, 32'h1234_56AB, 32'hFFFF_FFFF, 0);
    n_cmp++; if (be_s !== 4'b1100 || wd_s !== 32'h56AB_56AB) begin n_bad++; $display("FAIL sh_be_wdata: got %b/%h want 1100/56ab56ab", be_s, wd_s); end
    finish_op();
    run_op(SW, 32'h0, 32'h1234_56AB, 32'hFFFF_FFFF, 1);
    n_cmp++; if (be_s !== 4'b1111 || wd_s !== 32'h1234_56AB || addr_s !== 32'h0) begin n_bad++; $display("FAIL sw_fields: got %b/%h/%h want 1111/123456ab/0", be_s, wd_s, addr_s); end
    n_cmp++; if (mem_data !== 32'h8001_1234 || mem_err !== 1'b0) begin n_bad++; $display("FAIL sw_keep_data: got %h/%b want 80011234/0", mem_data, mem_err); end
    finish_op();
  endtask

  task automatic test_misaligned();
    run_op(LW, 32'h101, 32'h0, 32'h1111_1111, 0);
    n_cmp++; if (rq_n !== 0 || st_n !== 1) begin n_bad++; $display("FAIL mis_lw_timing: got req %0d stall %0d want 0/1", rq_n, st_n); end
    n_cmp++; if (mem_err !== 1'b1 || mem_data !== 32'h0) begin n_bad++; $display("FAIL mis_lw_result: got %b/%h want 1/0", mem_err, mem_data); end
    finish_op();
    run_op(LBU, 32'h3, 32'h0, 32'hAB00_0000, 0);
    n_cmp++; if (mem_err !== 1'b0 || mem_data !== 32'h0000_00AB) begin n_bad++; $display("FAIL byte_any_lane: got %b/%h want 0/000000ab", mem_err, mem_data); end
    finish_op();
    run_op(SH, 32'h3, 32'h0, 32'h0, 0);
    n_cmp++; if (rq_n !== 0 || st_n !== 1 || mem_err !== 1'b1 || mem_data !== 32'h0) begin n_bad++; $display("FAIL mis_sh: got req %0d stall %0d err %b data %h want 0/1/1/0", rq_n, st_n, mem_err, mem_data); end
    finish_op();
  endtask

  task automatic test_timeout();
    run_op(LW, 32'h200, 32'h0, 32'h5555_5555, 1000);
    n_cmp++; if (rq_n !== 4 || st_n !== 5) begin n_bad++; $display("FAIL to_cycles: got req %0d stall %0d want 4/5", rq_n, st_n); end
    n_cmp++; if (mem_err !== 1'b1 || mem_data !== 32'h0 || bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL to_result: got %b/%h/%b want 1/0/0", mem_err, mem_data, bus.dmem_req); end
    finish_op();
    run_op(LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    n_cmp++; if (mem_err !== 1'b0 || mem_data !== 32'hDEAD_BEEF || st_n !== 2) begin n_bad++; $display("FAIL to_recover: got %b/%h/%0d want 0/deadbeef/2", mem_err, mem_data, st_n); end
    finish_op();
  endtask

  task automatic test_nonmem();
    operation = NOP; bus.dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (stall !== 1'b0 || bus.dmem_req !== 1'b0 || mem_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL nonmem_hold: got stall %b req %b data %h want 0/0/deadbeef", stall, bus.dmem_req, mem_data); end
    end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(LW, 32'h300, 32'h0, 32'h0102_0304, 0);
    cyc();
    run_op(LBU, 32'h301, 32'h0, 32'h0102_0304, 0);
    n_cmp++; if (mem_data !== 32'h0000_0003 || st_n !== 2 || rq_n !== 1) begin n_bad++; $display("FAIL b2b: got %h stall %0d req %0d want 00000003/2/1", mem_data, st_n, rq_n); end
    finish_op();
  endtask

  task automatic test_reset_mid_req();
    operation = LW; alu_result = 32'h400; bus.dmem_ack = 1'b0;
    cyc(); cyc();
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_bad++; $display("FAIL mid_req_pre: got %b want 1", bus.dmem_req); end
    #2 rst_n = 1'b0; operation = NOP;
    #1;
    n_cmp++; if (bus.dmem_req !== 1'b0 || bus.dmem_be !== 4'd0 || bus.dmem_addr !== 32'd0 || mem_data !== 32'd0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL mid_req_rst: got req %b be %b addr %h data %h err %b want all 0", bus.dmem_req, bus.dmem_be, bus.dmem_addr, mem_data, mem_err); end
    cyc();
    rst_n = 1'b1; bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h7777_7777;
    cyc(); cyc();
    n_cmp++; if (bus.dmem_req !== 1'b0 || mem_data !== 32'd0 || stall !== 1'b0) begin n_bad++; $display("FAIL late_ack: got req %b data %h stall %b want 0/0/0", bus.dmem_req, mem_data, stall); end
    run_op(LHU, 32'h402, 32'h0, 32'hCAFE_0000, 0);
    n_cmp++; if (mem_data !== 32'h0000_CAFE || mem_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_op: got %h/%b want 0000cafe/0", mem_data, mem_err); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_nonmem();
    test_back_to_back();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the ALU and `write_back`. It turns load/store operations into single-beat requests on a req/ack data-memory bus and stalls the core until the access completes. For loads it extracts, sign- or zero-extends and holds the 32-bit result on `mem_data` for `write_back`. It also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ without `dmem_ack` before the access aborts. Legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `operation`  in  7  decoded op: 26 lb, 27 lh, 28 lw, 29 lbu, 30 lhu, 31 sb, 32 sh, 33 sw; any other value is a non-memory op.
- `alu_result`  in  32  effective byte address.
- `store_data`  in  32  rs2 value for stores.
- `mem_data`  out  32  load result to `write_back`; registered.
- `stall`  out  1  holds PC and the pipeline while high.
- `mem_err`  out  1  misaligned or timeout on the access just completed; registered; valid in DONE.
- `dmem_req`  out  1  request strobe; registered.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{alu_result[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ack`  in  1  access complete; read data is valid in the same cycle.
- `dmem_rdata`  in  32  read data.

## Operation
States: IDLE, REQ, DONE.

IDLE:
- A memory op with a misaligned address goes to DONE. `mem_err` is set to 1 and `mem_data` to 0. No request is issued.
- Misaligned means: lh/lhu/sh with `addr[0]=1`; lw/sw with `addr[1:0]!=0`.
- Any other memory op goes to REQ. The request fields are registered and `dmem_req` is set to 1.
- A non-memory op stays in IDLE. `mem_data` and `mem_err` hold their values.

REQ:
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are held stable.
- On `dmem_ack=1`:
  - Loads capture the extracted `dmem_rdata` into `mem_data`.
  - `mem_err` is set to 0.
  - `dmem_req` drops and the FSM goes to DONE.
- On the timeout condition:
  - The timeout counter starts at 0 on REQ entry and increments each REQ cycle without ack.
  - It fires when the counter reaches `TIMEOUT-1` and ack is still 0.
  - `mem_err` is set to 1, `mem_data` to 0, `dmem_req` drops, and the FSM goes to DONE.

DONE:
- Always returns to IDLE on the next cycle.

Stores:
- `mem_data` is unchanged.
- Lane = `addr[1:0]`.
- sb: `be = 4'b0001<<lane`, wdata = `{4{store_data[7:0]}}`.
- sh: `be = 4'b0011<<(2*addr[1])`, wdata = `{2{store_data[15:0]}}`.
- sw: `be = 4'b1111`, wdata = `store_data`.

Loads (`dmem_we=0`, `dmem_be=4'b1111`):
- lb/lbu: byte `rdata[8*lane+7 : 8*lane]`, sign-extended for lb, zero-extended for lbu.
- lh/lhu: half `rdata[16*addr[1]+15 : 16*addr[1]]`, sign-extended for lh, zero-extended for lhu.
- lw: `rdata` as-is.

`stall` (combinational) = memory op present AND state != DONE.

## Timing
- Reset (async, immediate): state IDLE; `dmem_req=0`, `dmem_we=0`, `dmem_be=0`, `dmem_addr=0`, `dmem_wdata=0`, `mem_data=0`, `mem_err=0`, timeout counter 0.
- Reset asserted in REQ drops `dmem_req` immediately. A late ack after reset is ignored in IDLE.
- Best-case memory op, ack in the first REQ cycle: cycle 0 IDLE (stall=1), cycle 1 REQ (req=1, ack=1), cycle 2 DONE (stall=0, `mem_data` valid). The instruction takes 3 cycles.
- Each extra wait cycle without ack adds 1 cycle.
- Misaligned op: cycle 0 IDLE (stall=1), cycle 1 DONE (stall=0, `mem_err=1`).
- Timeout: exactly `TIMEOUT` cycles with `dmem_req=1`, then DONE.
- `dmem_ack` is sampled only in REQ and ignored in IDLE and DONE.
- A memory op arriving in the cycle after DONE starts a new access from IDLE. Back-to-back accesses have no gap other than DONE→IDLE.
- Non-memory ops never stall.

## Test plan
- Reset mid-REQ: deassert `rst_n` while `dmem_req=1` → all outputs 0 within the same cycle; state IDLE after release.
- lb at addr 0x103 with ack after 1 cycle, `rdata=0x80AA_BBCC` → `be=1111`, `dmem_addr=0x100`, `mem_data=0xFFFF_FF80` in DONE; lbu same → `0x0000_0080`; stall high for exactly 2 cycles.
- lh at addr 0x102, `rdata=0x8001_1234` → `mem_data=0xFFFF_8001`; lhu → `0x0000_8001`; lw 0x100 → `0x8001_1234`.
- sb addr 0x2 with `store_data=0x1234_56AB` → `dmem_we=1`, `be=0100`, `wdata=0xABAB_ABAB`; sh addr 0x2 → `be=1100`, `wdata=0x56AB_56AB`; sw → `be=1111`; `mem_data` unchanged.
- Misaligned lw at addr 0x101 → no `dmem_req`, stall 1 cycle, `mem_err=1`, `mem_data=0`; sh at addr 0x3 behaves the same.
- `TIMEOUT=4`, ack never asserted → `dmem_req` high exactly 4 cycles, then DONE with `mem_err=1`; the following lw with ack on its first REQ cycle completes with `mem_err=0`.
